spi_frame_receiver: RTL

SPI_FRAME_RECEIVER -- requirements
Module: spi_frame_receiver

---
 rtl/spi_frame_receiver_pkg.sv | 11 +
 rtl/spi_frame_receiver_if.sv | 26 ++
 rtl/spi_frame_receiver_input_synchronizer.sv | 30 +++
 rtl/spi_frame_receiver.sv | 114 +++++++++++
 4 files changed

// File: rtl/spi_frame_receiver_pkg.sv
// Shared types and sizing for the SPI frame receiver slice.
package spi_frame_receiver_pkg;
  localparam int DFS_DEFAULT = 20;

  typedef enum logic [1:0] {IDLE, RECEIVE, DONE} state_t;

  // Counter must reach frame_size+1 so long frames stay distinguishable.
  function automatic int cnt_w(input int frame_size);
    return $clog2(frame_size + 2);
  endfunction
endpackage

// File: rtl/spi_frame_receiver_if.sv
// SPI lines in, captured frame and status out.
interface spi_frame_receiver_if
  import spi_frame_receiver_pkg::*;
#(
  parameter int DATA_FRAME_SIZE = DFS_DEFAULT
) ();
  logic                       ss_in;
  logic                       sclk_in;
  logic                       mosi_in;
  logic                       miso_in;
  logic [DATA_FRAME_SIZE-1:0] mosi_data;
  logic [DATA_FRAME_SIZE-1:0] miso_data;
  logic                       frame_valid;
  logic                       frame_error;
  logic                       comm_active;

  modport master (
    output ss_in, sclk_in, mosi_in, miso_in,
    input  mosi_data, miso_data, frame_valid, frame_error, comm_active
  );

  modport slave (
    input  ss_in, sclk_in, mosi_in, miso_in,
    output mosi_data, miso_data, frame_valid, frame_error, comm_active
  );
endinterface

// File: rtl/spi_frame_receiver_input_synchronizer.sv
// Multi-flop synchronizer plus history flop giving single-cycle edge pulses.
module input_synchronizer
  import spi_frame_receiver_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   hist;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      chain <= '0;
      hist  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      hist  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;
endmodule

// File: rtl/spi_frame_receiver.sv
// SPI slave-side frame capture: synchronizes raw SPI lines onto sys_clk and
// shifts mosi/miso frames while ss is high.
module spi_frame_receiver
  import spi_frame_receiver_pkg::*;
#(
  parameter int DATA_FRAME_SIZE = DFS_DEFAULT,
  parameter int SYNC_STAGES     = 2
) (
  input logic               sys_clk,
  input logic               rst,
  spi_frame_receiver_if.slave bus
);
  localparam int NUM_LINES = 4;
  localparam int CNT_W     = cnt_w(DATA_FRAME_SIZE);
  localparam int SS = 3, SCLK = 2, MOSI = 1, MISO = 0;

  logic [NUM_LINES-1:0] raw, sync, rise, fall;
  assign raw = {bus.ss_in, bus.sclk_in, bus.mosi_in, bus.miso_in};

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_sync
    input_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .sys_clk (sys_clk),
      .rst     (rst),
      .din     (raw[i]),
      .sync    (sync[i]),
      .rise    (rise[i]),
      .fall    (fall[i])
    );
  end

  logic unused_edges;
  assign unused_edges = ^{sync[SCLK], rise[MOSI], rise[MISO], fall[SCLK], fall[MOSI], fall[MISO]};

  state_t                     state, nxt;
  logic                       clr, shift_en, load;
  logic [CNT_W-1:0]           bit_cnt;
  logic [DATA_FRAME_SIZE-1:0] mosi_sr, miso_sr, mosi_q, miso_q;
  logic                       valid_q, error_q;

  // An ss rise only starts a frame once ss has been seen low with a filled
  // chain; a frame already in flight at reset release is thereby skipped.
  logic [SYNC_STAGES:0] vld_pipe;
  logic                 armed;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      vld_pipe <= '0;
      armed    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
      if (vld_pipe[SYNC_STAGES] && !sync[SS]) armed <= 1'b1;
    end
  end

  always_comb begin
    nxt      = state;
    clr      = 1'b0;
    shift_en = 1'b0;
    load     = 1'b0;
    unique case (state)
      IDLE: if (rise[SS] && armed) begin
        nxt = RECEIVE;
        clr = 1'b1;
      end
      RECEIVE: begin
        shift_en = rise[SCLK];
        if (fall[SS]) nxt = DONE;
      end
      DONE: begin
        load = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      mosi_sr <= '0;
      miso_sr <= '0;
      mosi_q  <= '0;
      miso_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state <= nxt;
      if (clr) begin
        bit_cnt <= '0;
        mosi_sr <= '0;
        miso_sr <= '0;
      end else if (shift_en) begin
        if (bit_cnt < CNT_W'(DATA_FRAME_SIZE)) begin
          mosi_sr <= {mosi_sr[DATA_FRAME_SIZE-2:0], sync[MOSI]};
          miso_sr <= {miso_sr[DATA_FRAME_SIZE-2:0], sync[MISO]};
        end
        if (bit_cnt != CNT_W'(DATA_FRAME_SIZE + 1)) bit_cnt <= bit_cnt + 1'b1;
      end
      valid_q <= load;
      error_q <= load && (bit_cnt != CNT_W'(DATA_FRAME_SIZE));
      if (load) begin
        mosi_q <= mosi_sr;
        miso_q <= miso_sr;
      end
    end
  end

  assign bus.mosi_data   = mosi_q;
  assign bus.miso_data   = miso_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_error = error_q;
  assign bus.comm_active = (state == RECEIVE);
endmodule
